// File: rtl/regfile_wr_arbiter_pkg.sv
// Shared constants, source encoding and helpers for the register-file write arbiter.
package regfile_wr_arbiter_pkg;

   localparam int AW   = 6;
   localparam int DW   = 32;
   localparam int NREG = 2 ** AW;

   typedef enum logic {
      SRC_ALU = 1'b0,
      SRC_MEM = 1'b1
   } src_e;

   function automatic logic [AW:0] popcount(input logic [NREG-1:0] v);
      logic [AW:0] n;
      n = '0;
      for (int i = 0; i < NREG; i++) n = n + {{AW{1'b0}}, v[i]};
      return n;
   endfunction

endpackage

// File: rtl/regarb_scoreboard.sv
// Pending-write scoreboard: one bit per register, set on reservation and cleared on
// an accepted writeback, with a registered population count and operand hazard lookup.
module regarb_scoreboard
   import regfile_wr_arbiter_pkg::*;
(
   input  logic          clk,
   input  logic          rst_n,
   input  logic          flush,
   input  logic          set_vld,
   input  logic [AW-1:0] set_rd,
   input  logic          clr_vld,
   input  logic [AW-1:0] clr_rd,
   input  logic [AW-1:0] rs,
   input  logic [AW-1:0] rt,
   output logic          hazard,
   output logic [AW:0]   pending
);

   logic [NREG-1:0] sb;
   logic [NREG-1:0] sb_next;

   always_comb begin
      // NOTE: assign the default before any branch so no path leaves sb_next unassigned (latch).
      sb_next = sb;
      if (flush) begin
         sb_next = '0;
      end else begin
         if (clr_vld) sb_next[clr_rd] = 1'b0;
         // applied after the clear so a same-cycle reservation of the same register wins
         if (set_vld && set_rd != '0) sb_next[set_rd] = 1'b1;
      end
   end

   // NOTE: the scoreboard is plain flops, not a RAM macro, so it takes the async reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sb      <= '0;
         pending <= '0;
      end else begin
         sb      <= sb_next;
         pending <= popcount(sb_next);
      end
   end

   // register 0 is hard-wired, so it never reports a hazard
   assign hazard = (sb[rs] && rs != '0) || (sb[rt] && rt != '0);

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Round-robin arbiter sharing the register-file write port between ALU and load writeback.
// Define REGARB_SCOREBOARD_EN to build the pending-write scoreboard (hazard, pending).
module regfile_wr_arbiter
   import regfile_wr_arbiter_pkg::*;
(
   input  logic          clk,
   input  logic          rst_n,
   input  logic          flush,
   input  logic          alu_vld,
   input  logic [AW-1:0] alu_rd,
   input  logic [DW-1:0] alu_data,
   output logic          alu_rdy,
   input  logic          mem_vld,
   input  logic [AW-1:0] mem_rd,
   input  logic [DW-1:0] mem_data,
   output logic          mem_rdy,
   input  logic          rsv_vld,
   input  logic [AW-1:0] rsv_rd,
   input  logic [AW-1:0] rs,
   input  logic [AW-1:0] rt,
   output logic          hazard,
   output logic          wr_en,
   output logic [AW-1:0] wr_addr,
   output logic [DW-1:0] wr_data,
   output logic [AW:0]   pending
);

   src_e          rr_ptr;
   logic          contended;
   logic          acc_vld;
   logic [AW-1:0] acc_rd;
   logic [DW-1:0] acc_data;

   always_comb begin
      contended = alu_vld && mem_vld;
      alu_rdy   = 1'b0;
      mem_rdy   = 1'b0;
      if (!flush) begin
         if (contended) begin
            alu_rdy = (rr_ptr == SRC_ALU);
            mem_rdy = (rr_ptr == SRC_MEM);
         end else begin
            alu_rdy = alu_vld;
            mem_rdy = mem_vld;
         end
      end
      acc_vld  = alu_rdy || mem_rdy;
      acc_rd   = mem_rdy ? mem_rd   : alu_rd;
      acc_data = mem_rdy ? mem_data : alu_data;
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr  <= SRC_ALU;
         wr_en   <= 1'b0;
         wr_addr <= '0;
         wr_data <= '0;
      end else begin
         wr_en <= acc_vld && acc_rd != '0;
         if (acc_vld && acc_rd != '0) begin
            wr_addr <= acc_rd;
            wr_data <= acc_data;
         end
         // the loser of a contended grant gets priority next time
         if (contended && !flush) rr_ptr <= (rr_ptr == SRC_ALU) ? SRC_MEM : SRC_ALU;
      end
   end

`ifdef REGARB_SCOREBOARD_EN
   regarb_scoreboard u_scoreboard (
      .clk     (clk),
      .rst_n   (rst_n),
      .flush   (flush),
      .set_vld (rsv_vld),
      .set_rd  (rsv_rd),
      .clr_vld (acc_vld),
      .clr_rd  (acc_rd),
      .rs      (rs),
      .rt      (rt),
      .hazard  (hazard),
      .pending (pending)
   );
`else
   logic unused_sb_inputs;
   assign unused_sb_inputs = ^{rsv_vld, rsv_rd, rs, rt};
   assign hazard           = 1'b0;
   assign pending          = '0;
`endif

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Self-checking bench for regfile_wr_arbiter: directed scenarios plus randomized traffic
// checked against a behavioural model of the arbitration and scoreboard rules.
module tb_regfile_wr_arbiter;
   import regfile_wr_arbiter_pkg::*;

`ifdef REGARB_SCOREBOARD_EN
   localparam bit SB_EN = 1'b1;
`else
   localparam bit SB_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst_n;
   logic          flush;
   logic          alu_vld;
   logic [AW-1:0] alu_rd;
   logic [DW-1:0] alu_data;
   logic          alu_rdy;
   logic          mem_vld;
   logic [AW-1:0] mem_rd;
   logic [DW-1:0] mem_data;
   logic          mem_rdy;
   logic          rsv_vld;
   logic [AW-1:0] rsv_rd;
   logic [AW-1:0] rs;
   logic [AW-1:0] rt;
   logic          hazard;
   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [DW-1:0] wr_data;
   logic [AW:0]   pending;

   int n_pass  = 0;
   int n_total = 0;

   // reference model state
   bit            m_turn_mem;
   bit            m_sb [NREG];
   bit            m_wr_en;
   logic [AW-1:0] m_wr_addr;
   logic [DW-1:0] m_wr_data;
   bit            e_alu_rdy, e_mem_rdy, e_hazard;

   regfile_wr_arbiter dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .flush    (flush),
      .alu_vld  (alu_vld),
      .alu_rd   (alu_rd),
      .alu_data (alu_data),
      .alu_rdy  (alu_rdy),
      .mem_vld  (mem_vld),
      .mem_rd   (mem_rd),
      .mem_data (mem_data),
      .mem_rdy  (mem_rdy),
      .rsv_vld  (rsv_vld),
      .rsv_rd   (rsv_rd),
      .rs       (rs),
      .rt       (rt),
      .hazard   (hazard),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .pending  (pending)
   );

   always #5 clk = ~clk;

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic idle();
      flush = 0; alu_vld = 0; alu_rd = '0; alu_data = '0;
      mem_vld = 0; mem_rd = '0; mem_data = '0;
      rsv_vld = 0; rsv_rd = '0; rs = '0; rt = '0;
   endtask

   task automatic model_reset();
      m_turn_mem = 0;
      foreach (m_sb[i]) m_sb[i] = 0;
      m_wr_en = 0; m_wr_addr = '0; m_wr_data = '0;
   endtask

   function automatic int m_pending();
      int n = 0;
      foreach (m_sb[i]) n += int'(m_sb[i]);
      return n;
   endfunction

   // Expected combinational outputs for the inputs currently applied.
   task automatic model_eval();
      e_alu_rdy = 0;
      e_mem_rdy = 0;
      if (!flush) begin
         if (alu_vld && mem_vld) begin
            e_mem_rdy = m_turn_mem;
            e_alu_rdy = !m_turn_mem;
         end else begin
            e_alu_rdy = alu_vld;
            e_mem_rdy = mem_vld;
         end
      end
      e_hazard = (rs != 0 && m_sb[rs]) || (rt != 0 && m_sb[rt]);
   endtask

   // Advance the model by one clock using the pre-edge inputs, then step past the edge.
   task automatic tick();
      logic [AW-1:0] rd;
      logic [DW-1:0] d;
      model_eval();
      if (flush) begin
         foreach (m_sb[i]) m_sb[i] = 0;
         m_wr_en = 0;
      end else begin
         m_wr_en = 0;
         if (e_alu_rdy || e_mem_rdy) begin
            rd = e_mem_rdy ? mem_rd : alu_rd;
            d  = e_mem_rdy ? mem_data : alu_data;
            m_sb[rd] = 0;
            if (rd != 0) begin
               m_wr_en = 1; m_wr_addr = rd; m_wr_data = d;
            end
         end
         if (alu_vld && mem_vld) m_turn_mem = !m_turn_mem;
         if (SB_EN && rsv_vld && rsv_rd != 0) m_sb[rsv_rd] = 1;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 0;
      idle();
      model_reset();
      #2;
      n_total++;
      if ({wr_en, wr_addr, wr_data, pending, hazard} !== '0) begin
         $display("FAIL reset_state: wr_en=%0b wr_addr=%0d wr_data=%0h pending=%0d hazard=%0b, want all 0",
                  wr_en, wr_addr, wr_data, pending, hazard);
      end else n_pass++;
      alu_vld = 1; alu_rd = 6'd12; alu_data = 32'h5;
      #1;
      n_total++;
      if (alu_rdy !== 1'b1 || mem_rdy !== 1'b0) begin
         $display("FAIL reset_rdy_comb: alu_rdy=%0b mem_rdy=%0b, want 1 0", alu_rdy, mem_rdy);
      end else n_pass++;
      @(negedge clk);
      rst_n = 1;
   endtask

   task automatic test_single();
      #1;
      n_total++;
      if (alu_rdy !== 1'b1) $display("FAIL single_rdy: alu_rdy=%0b, want 1", alu_rdy);
      else n_pass++;
      tick();
      idle();
      n_total++;
      if (wr_en !== 1'b1 || wr_addr !== 6'd12 || wr_data !== 32'h5) begin
         $display("FAIL single_write: wr_en=%0b wr_addr=%0d wr_data=%0h, want 1 12 5", wr_en, wr_addr, wr_data);
      end else n_pass++;
   endtask

   task automatic test_back_to_back();
      alu_vld = 1; alu_rd = 6'd3; alu_data = 32'hA0A0;
      mem_vld = 1; mem_rd = 6'd4; mem_data = 32'hB0B0;
      for (int i = 0; i < 4; i++) begin
         #1;
         n_total++;
         if (alu_rdy !== (i % 2 == 0) || mem_rdy !== (i % 2 == 1)) begin
            $display("FAIL contend_rdy[%0d]: alu_rdy=%0b mem_rdy=%0b, want %0b %0b",
                     i, alu_rdy, mem_rdy, i % 2 == 0, i % 2 == 1);
         end else n_pass++;
         tick();
         n_total++;
         if (wr_en !== 1'b1 || wr_addr !== ((i % 2 == 0) ? 6'd3 : 6'd4)) begin
            $display("FAIL contend_write[%0d]: wr_en=%0b wr_addr=%0d, want 1 %0d",
                     i, wr_en, wr_addr, (i % 2 == 0) ? 3 : 4);
         end else n_pass++;
      end
      idle();
   endtask

   task automatic test_rd_zero();
      mem_vld = 1; mem_rd = '0; mem_data = 32'hFFFF;
      #1;
      n_total++;
      if (mem_rdy !== 1'b1) $display("FAIL rd0_rdy: mem_rdy=%0b, want 1", mem_rdy);
      else n_pass++;
      tick();
      idle();
      n_total++;
      if (wr_en !== 1'b0) $display("FAIL rd0_no_write: wr_en=%0b, want 0", wr_en);
      else n_pass++;
   endtask

   task automatic test_scoreboard();
      rsv_vld = 1; rsv_rd = 6'd10;
      tick();
      idle();
      rs = 6'd10;
      #1;
      n_total++;
      if (hazard !== SB_EN || pending !== 7'(SB_EN ? 1 : 0)) begin
         $display("FAIL sb_reserve: hazard=%0b pending=%0d, want %0b %0d", hazard, pending, SB_EN, SB_EN ? 1 : 0);
      end else n_pass++;
      alu_vld = 1; alu_rd = 6'd10; alu_data = 32'h1234;
      #1;
      n_total++;
      if (hazard !== SB_EN) $display("FAIL sb_no_bypass: hazard=%0b, want %0b", hazard, SB_EN);
      else n_pass++;
      tick();
      alu_vld = 0;
      #1;
      n_total++;
      if (hazard !== 1'b0 || pending !== 7'd0) begin
         $display("FAIL sb_release: hazard=%0b pending=%0d, want 0 0", hazard, pending);
      end else n_pass++;
      // reservation and writeback of the same register in one cycle
      rsv_vld = 1; rsv_rd = 6'd7;
      tick();
      alu_vld = 1; alu_rd = 6'd7; alu_data = 32'h77;
      tick();
      idle();
      rs = 6'd7;
      #1;
      n_total++;
      if (hazard !== SB_EN || pending !== 7'(SB_EN ? 1 : 0)) begin
         $display("FAIL sb_set_wins: hazard=%0b pending=%0d, want %0b %0d", hazard, pending, SB_EN, SB_EN ? 1 : 0);
      end else n_pass++;
      alu_vld = 1; alu_rd = 6'd7;
      tick();
      idle();
   endtask

   task automatic test_flush();
      rsv_vld = 1; rsv_rd = 6'd5;
      tick();
      rsv_rd = 6'd6;
      tick();
      idle();
      n_total++;
      if (pending !== 7'(SB_EN ? 2 : 0)) $display("FAIL flush_pre_pending: pending=%0d, want %0d", pending, SB_EN ? 2 : 0);
      else n_pass++;
      flush = 1; alu_vld = 1; alu_rd = 6'd9; alu_data = 32'h99;
      rsv_vld = 1; rsv_rd = 6'd11;
      #1;
      n_total++;
      if (alu_rdy !== 1'b0 || mem_rdy !== 1'b0) begin
         $display("FAIL flush_rdy: alu_rdy=%0b mem_rdy=%0b, want 0 0", alu_rdy, mem_rdy);
      end else n_pass++;
      tick();
      idle();
      n_total++;
      if (wr_en !== 1'b0 || pending !== 7'd0) begin
         $display("FAIL flush_clear: wr_en=%0b pending=%0d, want 0 0", wr_en, pending);
      end else n_pass++;
   endtask

   task automatic test_random();
      bit first = 1;
      for (int cyc = 0; cyc < 400; cyc++) begin
         if (first || e_alu_rdy || !alu_vld) begin
            alu_vld  = ($urandom_range(0, 9) < 6);
            alu_rd   = AW'($urandom_range(0, 15));
            alu_data = $urandom;
         end
         if (first || e_mem_rdy || !mem_vld) begin
            mem_vld  = ($urandom_range(0, 9) < 5);
            mem_rd   = AW'($urandom_range(0, 15));
            mem_data = $urandom;
         end
         first   = 0;
         flush   = ($urandom_range(0, 19) == 0);
         rsv_vld = ($urandom_range(0, 9) < 4);
         rsv_rd  = AW'($urandom_range(0, 15));
         rs      = AW'($urandom_range(0, 15));
         rt      = AW'($urandom_range(0, 15));
         #1;
         model_eval();
         n_total++;
         if ({alu_rdy, mem_rdy, hazard} !== {e_alu_rdy, e_mem_rdy, e_hazard}) begin
            $display("FAIL rand_comb[%0d]: rdy/hazard=%b, want %b", cyc,
                     {alu_rdy, mem_rdy, hazard}, {e_alu_rdy, e_mem_rdy, e_hazard});
         end else n_pass++;
         tick();
         n_total++;
         if (wr_en !== m_wr_en || pending !== 7'(m_pending()) ||
             (m_wr_en && (wr_addr !== m_wr_addr || wr_data !== m_wr_data))) begin
            $display("FAIL rand_port[%0d]: wr_en=%0b addr=%0d data=%0h pending=%0d, want %0b %0d %0h %0d",
                     cyc, wr_en, wr_addr, wr_data, pending, m_wr_en, m_wr_addr, m_wr_data, m_pending());
         end else n_pass++;
      end
      idle();
      tick();
   endtask

   task automatic test_midstream_reset();
      alu_vld = 1; alu_rd = 6'd20; alu_data = 32'hCAFE;
      rsv_vld = 1; rsv_rd = 6'd21;
      tick();
      n_total++;
      if (wr_en !== 1'b1) $display("FAIL midreset_pre: wr_en=%0b, want 1", wr_en);
      else n_pass++;
      rst_n = 0;
      #1;
      n_total++;
      if (wr_en !== 1'b0 || wr_addr !== '0 || pending !== 7'd0) begin
         $display("FAIL midreset_async: wr_en=%0b wr_addr=%0d pending=%0d, want 0 0 0", wr_en, wr_addr, pending);
      end else n_pass++;
      model_reset();
      idle();
      @(negedge clk);
      rst_n = 1;
      tick();
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_rd_zero();
      test_scoreboard();
      test_flush();
      test_random();
      test_midstream_reset();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
